// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl - iterative sequencer for the ASCON permutation.
//
// Steps one external round datapath through p12, p8 or p6. The controller
// holds the 320-bit state between rounds, feeds the round core its state and
// round constant, and hands the result back through a valid/ready pair. This
// lets the round core be shared with the AEAD top instead of unrolling rounds.
//
// Optional feature: define ASCON_PERM_ABORT_EN to add the abort input, which
// drops an in-flight permutation back to IDLE. The state is kept.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   request: s_in and mode are valid
//   in_ready   controller idle; a request is taken on in_valid & in_ready
//   mode       0 = p12, 1 = p8, 2 = p6, 3 = reserved (runs as p12)
//   s_in       input state {x0,x1,x2,x3,x4}, x0 in [319:256]
//   out_valid  s_out holds the permuted state
//   out_ready  consumer takes s_out on out_valid & out_ready
//   s_out      permuted state (the state register)
//   busy       high while a permutation is running or waiting to be taken
//   rnd_s      state to the round core (the state register)
//   rnd_c      round constant to the round core
//   rnd_sout   round core result, valid ROUND_LAT cycles after rnd_s/rnd_c
//   abort      (ASCON_PERM_ABORT_EN only) cancel the running permutation
module ascon_perm_ctrl #(
    parameter int ROUND_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [319:0] s_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] s_out,
    output logic         busy,
    output logic [319:0] rnd_s,
    output logic [7:0]   rnd_c,
`ifdef ASCON_PERM_ABORT_EN
    input  logic         abort,
`endif
    input  logic [319:0] rnd_sout
);

    localparam int LW = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(ROUND_LAT - 1);
    localparam logic [3:0] LAST_IDX = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        fsm;
    logic [319:0]  st_reg;
    logic [3:0]    idx;
    logic [LW-1:0] lat_cnt;
    logic          abort_req;

`ifdef ASCON_PERM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Shorter permutations are the tail of p12: they start later in the
    // constant table and always finish on index 11.
    function automatic logic [3:0] start_idx(input logic [1:0] m);
        case (m)
            2'd1:    return 4'd4;
            2'd2:    return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    assign s_out = st_reg;
    assign rnd_s = st_reg;
    assign rnd_c = (fsm == RUN) ? {4'hF - idx, idx} : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            st_reg    <= '0;
            idx       <= '0;
            lat_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st_reg   <= s_in;
                        idx      <= start_idx(mode);
                        lat_cnt  <= LAT_INIT;
                        fsm      <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        fsm      <= IDLE;
                        idx      <= '0;
                        lat_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (lat_cnt != '0) begin
                        // rnd_s stays on st_reg until the core result lands
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        st_reg  <= rnd_sout;
                        lat_cnt <= LAT_INIT;
                        if (idx == LAST_IDX) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (abort_req) begin
                        fsm       <= IDLE;
                        idx       <= '0;
                        lat_cnt   <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl. Two instances: unit 0 with a one-cycle round
// core, unit 1 with a two-cycle round core. Each round core is a behavioural
// ASCON round. Expected results come from a reference permutation built on
// the same round function with a hand-written constant table.
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [1:0]   mode      [2];
    logic [319:0] s_in      [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [319:0] s_out     [2];
    logic         busy      [2];
    logic [319:0] rnd_s     [2];
    logic [7:0]   rnd_c     [2];
    logic [319:0] rnd_sout  [2];
`ifdef ASCON_PERM_ABORT_EN
    logic         abort     [2];
`endif
    logic [319:0] core_q;

    int checks   = 0;
    int failures = 0;
    logic [319:0] exp_q0 [$];
    logic [319:0] exp_q1 [$];

    always #5 clk = ~clk;

    ascon_perm_ctrl #(.ROUND_LAT(1)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode[0]), .s_in(s_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .s_out(s_out[0]), .busy(busy[0]),
        .rnd_s(rnd_s[0]), .rnd_c(rnd_c[0]),
`ifdef ASCON_PERM_ABORT_EN
        .abort(abort[0]),
`endif
        .rnd_sout(rnd_sout[0])
    );

    ascon_perm_ctrl #(.ROUND_LAT(2)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mode(mode[1]), .s_in(s_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .s_out(s_out[1]), .busy(busy[1]),
        .rnd_s(rnd_s[1]), .rnd_c(rnd_c[1]),
`ifdef ASCON_PERM_ABORT_EN
        .abort(abort[1]),
`endif
        .rnd_sout(rnd_sout[1])
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        x2 = x2 ^ {56'h0, c};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [7:0] rc_of(input int i);
        case (i)
            0: return 8'hf0;  1: return 8'he1;  2: return 8'hd2;  3: return 8'hc3;
            4: return 8'hb4;  5: return 8'ha5;  6: return 8'h96;  7: return 8'h87;
            8: return 8'h78;  9: return 8'h69; 10: return 8'h5a; 11: return 8'h4b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int start_of(input logic [1:0] m);
        return (m == 2'd1) ? 4 : (m == 2'd2) ? 6 : 0;
    endfunction

    function automatic logic [319:0] ref_rounds(input logic [319:0] s, input int first, input int cnt);
        logic [319:0] v = s;
        for (int i = first; i < first + cnt; i++) v = round_fn(v, rc_of(i));
        return v;
    endfunction

    // Behavioural round cores: combinational for unit 0, one register for unit 1.
    assign rnd_sout[0] = round_fn(rnd_s[0], rnd_c[0]);
    always_ff @(posedge clk) core_q <= round_fn(rnd_s[1], rnd_c[1]);
    assign rnd_sout[1] = core_q;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: one pop per output handshake.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid[0] && out_ready[0]) begin
            if (exp_q0.size() == 0) chk("sb0_unexpected", s_out[0], 320'h0 - 1);
            else chk("sb0_result", s_out[0], exp_q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid[1] && out_ready[1]) begin
            if (exp_q1.size() == 0) chk("sb1_unexpected", s_out[1], 320'h0 - 1);
            else chk("sb1_result", s_out[1], exp_q1.pop_front());
        end
    end

    // Present one request, wait (bounded) for acceptance, then scramble the
    // inputs so any late sampling would corrupt the result.
    task automatic issue(input int k, input logic [1:0] m, input logic [319:0] s);
        int n = 0;
        while (!in_ready[k] && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        in_valid[k] = 1'b1;
        mode[k] = m;
        s_in[k] = s;
        if (k == 0) exp_q0.push_back(ref_rounds(s, start_of(m), 12 - start_of(m)));
        else exp_q1.push_back(ref_rounds(s, start_of(m), 12 - start_of(m)));
        step();
        in_valid[k] = 1'b0;
        mode[k] = ~m;
        s_in[k] = ~s;
    endtask

    task automatic run_perm(input int k, input int lat, input logic [1:0] m,
                            input logic [319:0] s, input int hold);
        int st;
        int nr;
        logic [319:0] e;
        st = start_of(m);
        nr = 12 - st;
        e = ref_rounds(s, st, nr);
        out_ready[k] = (hold > 0) ? 1'b0 : 1'b1;
        issue(k, m, s);
        for (int i = 0; i < nr * lat; i++) begin
            chk($sformatf("rnd_c_u%0d_c%0d", k, i), rnd_c[k], rc_of(st + i / lat));
            chk("valid_early", out_valid[k], 0);
            chk("in_ready_run", in_ready[k], 0);
            step();
        end
        chk("out_valid_latency", out_valid[k], 1);
        chk("in_ready_done", in_ready[k], 0);
        chk("busy_done", busy[k], 1);
        chk("rnd_c_done", rnd_c[k], 0);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", out_valid[k], 1);
            chk("hold_s_out", s_out[k], e);
            in_valid[k] = (i == 2);
            s_in[k] = ~s;
            mode[k] = 2'd2;
            step();
        end
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        step();
        chk("valid_fall", out_valid[k], 0);
        chk("in_ready_back", in_ready[k], 1);
        step();
        chk("idle_busy", busy[k], 0);
        chk("idle_valid", out_valid[k], 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            mode[k] = 2'd0;
            s_in[k] = '0;
            out_ready[k] = 1'b1;
`ifdef ASCON_PERM_ABORT_EN
            abort[k] = 1'b0;
`endif
        end
        step();
        step();
        chk("rst_in_ready", in_ready[0], 1);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_s_out", s_out[0], 0);
        chk("rst_rnd_s", rnd_s[0], 0);
        chk("rst_rnd_c", rnd_c[0], 0);
        chk("rst_in_ready_u1", in_ready[1], 1);
        rst = 1'b0;
        step();

        // T1: p12 on the zero state, then on a patterned state
        run_perm(0, 1, 2'd0, 320'h0, 0);
        run_perm(0, 1, 2'd0, {64'h0123456789abcdef, 64'hfedcba9876543210,
                              64'h0f1e2d3c4b5a6978, 64'h8000000000000001, 64'hdeadbeefcafef00d}, 0);
        // T2: p8
        run_perm(0, 1, 2'd1, {5{64'h5555aaaa3333cccc}}, 0);
        // T3: p6 with a two-cycle round core
        run_perm(1, 2, 2'd2, {64'h80400c0600000000, 256'h1}, 0);
        run_perm(1, 2, 2'd0, {5{64'h0011223344556677}}, 0);
        // T4: backpressure with an ignored request during DONE
        run_perm(0, 1, 2'd0, {64'h1, 64'h2, 64'h3, 64'h4, 64'h5}, 5);

        // T5: reset in the third round of p12 discards the result
        out_ready[0] = 1'b1;
        issue(0, 2'd0, {5{64'h9999999999999999}});
        step();
        step();
        rst = 1'b1;
        step();
        chk("t5_in_ready", in_ready[0], 1);
        chk("t5_out_valid", out_valid[0], 0);
        chk("t5_s_out", s_out[0], 0);
        chk("t5_busy", busy[0], 0);
        rst = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        step();
        run_perm(0, 1, 2'd1, {5{64'h0badc0de0badc0de}}, 0);

`ifdef ASCON_PERM_ABORT_EN
        // T6: abort during round 5 of p12 keeps the 4-round state
        begin
            logic [319:0] s6;
            int rose;
            s6 = {5{64'h7777000011112222}};
            issue(0, 2'd0, s6);
            for (int i = 0; i < 4; i++) step();
            abort[0] = 1'b1;
            step();
            abort[0] = 1'b0;
            chk("t6_in_ready", in_ready[0], 1);
            chk("t6_out_valid", out_valid[0], 0);
            chk("t6_busy", busy[0], 0);
            chk("t6_state_kept", s_out[0], ref_rounds(s6, 0, 4));
            exp_q0.delete();
            rose = 0;
            for (int i = 0; i < 15; i++) begin
                if (out_valid[0]) rose++;
                step();
            end
            chk("t6_never_valid", rose, 0);
        end
`endif
        // reserved mode runs as p12
        run_perm(0, 1, 2'd3, {5{64'h0123012301230123}}, 0);

        chk("sb0_empty", exp_q0.size(), 0);
        chk("sb1_empty", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
